// File: rtl/data_mem_32_if.sv
// Bus between the RV32I execute stage and the data memory.
// The core drives the address, store data and strobes; the memory returns load data and fault flags.
interface data_mem_32_if;
  logic [31:0] mem_addr;
  logic [31:0] wr_data;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  funct3;
  logic [31:0] rd_data;
  logic        misaligned;
  logic        fault_sticky;

  modport master (
    output mem_addr, wr_data, mem_write, mem_read, funct3,
    input  rd_data, misaligned, fault_sticky
  );

  modport slave (
    input  mem_addr, wr_data, mem_write, mem_read, funct3,
    output rd_data, misaligned, fault_sticky
  );
endinterface

// File: rtl/data_mem_32.sv
// Byte-addressable little-endian data memory with combinational sign/zero-extended loads,
// byte-lane stores, misalignment/illegal-access detection and a sticky fault bit.
module data_mem_32 #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  data_mem_32_if.slave  bus
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          fault_q;
  logic          fault_d;

  logic [AW-1:0] idx_s;
  logic [1:0]    lane_s;
  logic [31:0]   word_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic          align_bad_s;
  logic          ld_legal_s;
  logic          st_legal_s;
  logic          misaligned_s;
  logic          load_ok_s;
  logic          store_ok_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic [31:0]   rd_s;

  // Upper address bits are dropped, so accesses alias modulo the array size.
  assign idx_s  = bus.mem_addr[AW+1:2];
  assign lane_s = bus.mem_addr[1:0];
  assign word_s = mem_q[idx_s];
  assign byte_s = word_s[{lane_s, 3'b000} +: 8];
  assign half_s = bus.mem_addr[1] ? word_s[31:16] : word_s[15:0];

  // Access decode: legality per direction and natural alignment.
  always_comb begin
    align_bad_s = 1'b0;
    ld_legal_s  = 1'b0;
    st_legal_s  = 1'b0;
    case (bus.funct3)
      F3_B: begin
        ld_legal_s = 1'b1;
        st_legal_s = 1'b1;
      end
      F3_H: begin
        ld_legal_s  = 1'b1;
        st_legal_s  = 1'b1;
        align_bad_s = bus.mem_addr[0];
      end
      F3_W: begin
        ld_legal_s  = 1'b1;
        st_legal_s  = 1'b1;
        align_bad_s = |bus.mem_addr[1:0];
      end
      F3_BU: begin
        ld_legal_s = 1'b1;
      end
      F3_HU: begin
        ld_legal_s  = 1'b1;
        align_bad_s = bus.mem_addr[0];
      end
      default: begin
        ld_legal_s  = 1'b0;
        st_legal_s  = 1'b0;
        align_bad_s = 1'b0;
      end
    endcase
    // A combined read/write is rejected as a whole if either direction is bad.
    misaligned_s = (bus.mem_read  & (~ld_legal_s | align_bad_s)) |
                   (bus.mem_write & (~st_legal_s | align_bad_s));
    load_ok_s    = bus.mem_read  & ~misaligned_s;
    store_ok_s   = bus.mem_write & ~misaligned_s;
  end

  // Load extraction and extension.
  always_comb begin
    rd_s = 32'h0000_0000;
    if (load_ok_s) begin
      case (bus.funct3)
        F3_B:    rd_s = {{24{byte_s[7]}}, byte_s};
        F3_BU:   rd_s = {24'h00_0000, byte_s};
        F3_H:    rd_s = {{16{half_s[15]}}, half_s};
        F3_HU:   rd_s = {16'h0000, half_s};
        F3_W:    rd_s = word_s;
        default: rd_s = 32'h0000_0000;
      endcase
    end else begin
      rd_s = 32'h0000_0000;
    end
  end

  // Store lane enables with data replicated across lanes.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = 32'h0000_0000;
    case (bus.funct3)
      F3_B: begin
        be_s    = 4'b0001 << lane_s;
        wdata_s = {4{bus.wr_data[7:0]}};
      end
      F3_H: begin
        be_s    = bus.mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{bus.wr_data[15:0]}};
      end
      F3_W: begin
        be_s    = 4'b1111;
        wdata_s = bus.wr_data;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
      end
    endcase
  end

  assign fault_d = fault_q | misaligned_s;

  // Storage array and sticky fault; reset wipes the whole array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < int'(DEPTH_WORDS); w++) begin
        mem_q[w] <= 32'h0000_0000;
      end
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
      if (store_ok_s) begin
        for (int b = 0; b < 4; b++) begin
          if (be_s[b]) begin
            mem_q[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
          end
        end
      end
    end
  end

  assign bus.rd_data      = rd_s;
  assign bus.misaligned   = misaligned_s;
  assign bus.fault_sticky = fault_q;

endmodule

// File: tb/tb_data_mem_32.sv
// Scoreboard bench for data_mem_32: expected load data and flags are queued when a request
// is driven and popped when the combinational outputs are sampled.
module tb_data_mem_32;

  logic clk;
  logic rst_n;
  data_mem_32_if bus();

  data_mem_32 #(.DEPTH_WORDS(256), .AW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a request on the falling edge, so it is applied for the next rising edge.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] f3);
    @(negedge clk);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_addr  = addr;
    bus.wr_data   = data;
    bus.funct3    = f3;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] rd, input logic mis);
    exp_t e;
    e.tag = tag;
    e.rd  = rd;
    e.mis = mis;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    #2;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      check_val({e.tag, ".rd"},  bus.rd_data, e.rd);
      check_val({e.tag, ".mis"}, {31'd0, bus.misaligned}, {31'd0, e.mis});
    end
  endtask

  task automatic op(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                    input logic [31:0] data, input logic [2:0] f3,
                    input logic [31:0] exp_rd, input logic exp_mis);
    drive(rd, wr, addr, data, f3);
    push_exp(tag, exp_rd, exp_mis);
    pop_cmp();
  endtask

  task automatic st(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic [2:0] f3, input logic exp_mis);
    op(tag, 1'b0, 1'b1, addr, data, f3, 32'h0000_0000, exp_mis);
  endtask

  task automatic ld(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                    input logic [31:0] exp_rd, input logic exp_mis);
    op(tag, 1'b1, 1'b0, addr, 32'h0000_0000, f3, exp_rd, exp_mis);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = 32'h0000_0000;
    bus.wr_data   = 32'h0000_0000;
    bus.funct3    = 3'b000;
    #1;
    check_val("reset.fault", {31'd0, bus.fault_sticky}, 32'd0);
    check_val("reset.rd", bus.rd_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Word store then extended loads.
    st("sw10", 32'h10, 32'h8000_80F1, 3'b010, 1'b0);
    ld("lw10",  32'h10, 3'b010, 32'h8000_80F1, 1'b0);
    ld("lb10",  32'h10, 3'b000, 32'hFFFF_FFF1, 1'b0);
    ld("lbu10", 32'h10, 3'b100, 32'h0000_00F1, 1'b0);
    ld("lh12",  32'h12, 3'b001, 32'hFFFF_8000, 1'b0);
    ld("lhu12", 32'h12, 3'b101, 32'h0000_8000, 1'b0);

    // Lane isolation.
    st("sw20", 32'h20, 32'h1122_3344, 3'b010, 1'b0);
    st("sb21", 32'h21, 32'hFFFF_FFAA, 3'b000, 1'b0);
    st("sh22", 32'h22, 32'h1234_BEEF, 3'b001, 1'b0);
    ld("lw20",  32'h20, 3'b010, 32'hBEEF_AA44, 1'b0);
    ld("lb23",  32'h23, 3'b000, 32'hFFFF_FFBE, 1'b0);
    ld("lh20",  32'h20, 3'b001, 32'hFFFF_AA44, 1'b0);
    check_val("fault.pre", {31'd0, bus.fault_sticky}, 32'd0);

    // Misaligned store sets the sticky bit and writes nothing.
    st("sw31", 32'h31, 32'h1234_5678, 3'b010, 1'b1);
    op("idle", 1'b0, 1'b0, 32'h0, 32'h0, 3'b011, 32'h0, 1'b0);
    check_val("fault.post", {31'd0, bus.fault_sticky}, 32'd1);
    ld("lw30", 32'h30, 3'b010, 32'h0000_0000, 1'b0);
    ld("lh33", 32'h33, 3'b001, 32'h0000_0000, 1'b1);
    ld("lhu35", 32'h35, 3'b101, 32'h0000_0000, 1'b1);

    // Aliasing, wrap and illegal funct3.
    st("sw400", 32'h400, 32'hCAFE_0001, 3'b010, 1'b0);
    ld("lw0",   32'h0, 3'b010, 32'hCAFE_0001, 1'b0);
    ld("lw011", 32'h0, 3'b011, 32'h0000_0000, 1'b1);
    st("swtop", 32'hFFFF_FFFC, 32'h0000_0077, 3'b010, 1'b0);
    ld("lw3fc", 32'h3FC, 3'b010, 32'h0000_0077, 1'b0);
    st("st100", 32'h3FC, 32'hFFFF_FFFF, 3'b100, 1'b1);
    ld("lw3fc2", 32'h3FC, 3'b010, 32'h0000_0077, 1'b0);

    // Simultaneous read and write: old data before the edge, new after.
    st("sw40", 32'h40, 32'h0000_0005, 3'b010, 1'b0);
    op("rw40", 1'b1, 1'b1, 32'h40, 32'h0000_0009, 3'b010, 32'h0000_0005, 1'b0);
    ld("lw40", 32'h40, 3'b010, 32'h0000_0009, 1'b0);
    op("rw100", 1'b1, 1'b1, 32'h40, 32'h0000_00FF, 3'b100, 32'h0000_0000, 1'b1);
    ld("lw40b", 32'h40, 3'b010, 32'h0000_0009, 1'b0);

    // Asynchronous reset mid-cycle, no clock edge.
    drive(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    #2;
    rst_n = 1'b0;
    push_exp("rst.lw10", 32'h0000_0000, 1'b0);
    pop_cmp();
    check_val("rst.fault", {31'd0, bus.fault_sticky}, 32'd0);
    bus.mem_addr = 32'h11;
    push_exp("rst.lw11", 32'h0000_0000, 1'b1);
    pop_cmp();
    // Store across an edge while reset is held is discarded.
    drive(1'b0, 1'b1, 32'h50, 32'hDEAD_BEEF, 3'b010);
    @(negedge clk);
    bus.mem_write = 1'b0;
    // Release with a store pending: it commits on the first edge.
    rst_n = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_addr  = 32'h60;
    bus.wr_data   = 32'h0000_ABCD;
    bus.funct3    = 3'b010;
    ld("lw50", 32'h50, 3'b010, 32'h0000_0000, 1'b0);
    ld("lw60", 32'h60, 3'b010, 32'h0000_ABCD, 1'b0);
    ld("lw20r", 32'h20, 3'b010, 32'h0000_0000, 1'b0);
    check_val("rst.fault2", {31'd0, bus.fault_sticky}, 32'd0);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: %0d entries left", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
